ipml_hsst_pll_rst_ctrl_mc: RTL

Multi-channel HSST PLL power-up/reset sequencer. It runs one independent sequence per PLL: power-down hold, reset hold, lock wait with timeout and bounded retry, then lock monitoring with automatic re-reset on lock loss. It sits between the free-running fabric clock domain and the HSST PLL hard-macro controls, ahead of the lane/TX/RX reset sequencers, which gate on `o_pll_done`.

---
 rtl/ipml_hsst_rst_pkg.sv | 28 ++
 rtl/ipml_hsst_pll_rst_ch.sv | 191 +++++++++++++++++++
 rtl/ipml_hsst_pll_rst_ctrl_mc.sv | 73 +++++++
 3 files changed

// File: rtl/ipml_hsst_rst_pkg.sv
// Shared definitions for the HSST PLL reset sequencer: channel state
// encoding, microsecond-to-cycle conversion and synchroniser depth.
package ipml_hsst_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PD_HOLD   = 3'd1,
    ST_RST_HOLD  = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_DONE      = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_e;

  // Two flops between the asynchronous pll_lock and any decision logic.
  localparam int SYNC_DEPTH = 2;

  // Hold time in free-clock cycles, with a 2x margin over the nominal time.
  function automatic int calc_cnt(input int us, input int freq);
    return 2 * us * freq;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ipml_hsst_pll_rst_ch.sv
// Single-channel PLL power-up/reset sequencer: lock synchroniser plus
// the PD -> RST -> lock-wait -> monitor FSM with timeout retry.
module ipml_hsst_pll_rst_ch
  import ipml_hsst_rst_pkg::*;
#(
  parameter int PD_CNT      = 8000,
  parameter int RST_CNT     = 8200,
  parameter int TO_CNT      = 100000,
  parameter int LOCK_STABLE = 8,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       rst_req,
  output logic       pll_pd,
  output logic       pll_rst,
  output logic       pll_done,
  output logic       pll_fail,
  output logic       lock_loss,
  output logic [3:0] retry_cnt
);

  localparam int CNT_W = $clog2(max3(PD_CNT, RST_CNT, TO_CNT) + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_CNT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CNT - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CNT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  pll_state_e             state_q, state_d;
  logic [SYNC_DEPTH-1:0]  sync_q, sync_d;
  logic [CNT_W-1:0]       cntr_q, cntr_d;
  logic [STB_W-1:0]       stable_q, stable_d;
  logic [3:0]             retry_q, retry_d;
  logic                   pd_q, pd_d;
  logic                   rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic                   loss_q, loss_d;
  logic                   lock_s;
  logic                   lock_ok;
  logic                   timeout;
  logic [3:0]             retry_inc;

  assign lock_s  = sync_q[SYNC_DEPTH-1];
  assign lock_ok = lock_s && (stable_q == STB_LAST);
  assign timeout = (cntr_q == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Synchroniser and per-channel datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cntr_q   <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      pd_q     <= 1'b1;
      rst_q    <= 1'b1;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      loss_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cntr_q   <= cntr_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      pd_q     <= pd_d;
      rst_q    <= rst_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      loss_q   <= loss_d;
    end
  end

  // Next state; a restart request overrides every other transition, and a
  // lock that completes on the timeout cycle takes precedence over the timeout.
  always_comb begin
    state_d = state_q;
    if (rst_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_PD_HOLD;
        ST_PD_HOLD:   if (cntr_q == PD_LAST)  state_d = ST_RST_HOLD;
        ST_RST_HOLD:  if (cntr_q == RST_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_ok)      state_d = ST_DONE;
          else if (timeout) state_d = (retry_inc >= RETRY_MAX) ? ST_FAIL : ST_PD_HOLD;
        end
        ST_DONE:      if (!lock_s) state_d = ST_RST_HOLD;
        ST_FAIL:      state_d = ST_FAIL;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Counters and registered outputs for the transition being taken.
  always_comb begin
    sync_d    = {sync_q[SYNC_DEPTH-2:0], pll_lock};
    cntr_d    = cntr_q;
    stable_d  = stable_q;
    retry_d   = retry_q;
    pd_d      = pd_q;
    rst_d     = rst_q;
    done_d    = done_q;
    fail_d    = fail_q;
    loss_d    = 1'b0;
    retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    if (rst_req) begin
      cntr_d   = '0;
      stable_d = '0;
      retry_d  = '0;
      pd_d     = 1'b1;
      rst_d    = 1'b1;
      done_d   = 1'b0;
      fail_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pd_d   = 1'b1;
          rst_d  = 1'b1;
          done_d = 1'b0;
          cntr_d = '0;
        end
        ST_PD_HOLD: begin
          if (cntr_q == PD_LAST) begin
            pd_d   = 1'b0;
            cntr_d = '0;
          end else begin
            cntr_d = cntr_q + CNT_W'(1);
          end
        end
        ST_RST_HOLD: begin
          if (cntr_q == RST_LAST) begin
            rst_d    = 1'b0;
            cntr_d   = '0;
            stable_d = '0;
          end else begin
            cntr_d = cntr_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          cntr_d   = cntr_q + CNT_W'(1);
          stable_d = lock_s ? stable_q + STB_W'(1) : '0;
          if (lock_ok) begin
            done_d = 1'b1;
            cntr_d = '0;
          end else if (timeout) begin
            retry_d = retry_inc;
            pd_d    = 1'b1;
            rst_d   = 1'b1;
            cntr_d  = '0;
            if (retry_inc >= RETRY_MAX) fail_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (!lock_s) begin
            loss_d = 1'b1;
            done_d = 1'b0;
            rst_d  = 1'b1;
            cntr_d = '0;
          end
        end
        ST_FAIL: begin
          pd_d   = 1'b1;
          rst_d  = 1'b1;
          fail_d = 1'b1;
        end
        default: begin
          pd_d  = 1'b1;
          rst_d = 1'b1;
        end
      endcase
    end
  end

  assign pll_pd    = pd_q;
  assign pll_rst   = rst_q;
  assign pll_done  = done_q;
  assign pll_fail  = fail_q;
  assign lock_loss = loss_q;
  assign retry_cnt = retry_q;

endmodule

// File: rtl/ipml_hsst_pll_rst_ctrl_mc.sv
// Multi-channel HSST PLL power-up/reset sequencer: one independent
// channel sequencer per PLL plus a registered all-done flag.
// Define IPML_HSST_SPEEDUP_SIM_EN to shorten hold/timeout times for
// simulation (1/2/5 us instead of the parameter values).
module ipml_hsst_pll_rst_ctrl_mc
  import ipml_hsst_rst_pkg::*;
#(
  parameter int FREE_CLOCK_FREQ = 100,
  parameter int PLL_NUM         = 2,
  parameter int PD_TIME_US      = 40,
  parameter int RST_TIME_US     = 41,
  parameter int LOCK_TIMEOUT_US = 500,
  parameter int LOCK_STABLE     = 8,
  parameter int MAX_RETRY       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PLL_NUM-1:0]   pll_lock,
  input  logic [PLL_NUM-1:0]   i_pll_rst_req,
  output logic [PLL_NUM-1:0]   P_PLLPOWERDOWN,
  output logic [PLL_NUM-1:0]   P_PLL_RST,
  output logic [PLL_NUM-1:0]   o_pll_done,
  output logic [PLL_NUM-1:0]   o_pll_fail,
  output logic [PLL_NUM-1:0]   o_lock_loss,
  output logic [4*PLL_NUM-1:0] o_retry_cnt,
  output logic                 o_all_done
);

`ifdef IPML_HSST_SPEEDUP_SIM_EN
  localparam int PD_CNT  = calc_cnt(1, FREE_CLOCK_FREQ);
  localparam int RST_CNT = calc_cnt(2, FREE_CLOCK_FREQ);
  localparam int TO_CNT  = calc_cnt(5, FREE_CLOCK_FREQ);
`else
  localparam int PD_CNT  = calc_cnt(PD_TIME_US, FREE_CLOCK_FREQ);
  localparam int RST_CNT = calc_cnt(RST_TIME_US, FREE_CLOCK_FREQ);
  localparam int TO_CNT  = calc_cnt(LOCK_TIMEOUT_US, FREE_CLOCK_FREQ);
`endif

  logic all_done_q, all_done_d;

  for (genvar i = 0; i < PLL_NUM; i++) begin : g_ch
    ipml_hsst_pll_rst_ch #(
      .PD_CNT      (PD_CNT),
      .RST_CNT     (RST_CNT),
      .TO_CNT      (TO_CNT),
      .LOCK_STABLE (LOCK_STABLE),
      .MAX_RETRY   (MAX_RETRY)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_lock  (pll_lock[i]),
      .rst_req   (i_pll_rst_req[i]),
      .pll_pd    (P_PLLPOWERDOWN[i]),
      .pll_rst   (P_PLL_RST[i]),
      .pll_done  (o_pll_done[i]),
      .pll_fail  (o_pll_fail[i]),
      .lock_loss (o_lock_loss[i]),
      .retry_cnt (o_retry_cnt[4*i +: 4])
    );
  end

  // All channels done, computed from the registered per-channel flags.
  always_comb all_done_d = &o_pll_done;

  // Register the all-done flag so downstream sees it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_done_q <= 1'b0;
    else        all_done_q <= all_done_d;
  end

  assign o_all_done = all_done_q;

endmodule
